// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared widths, forward-select codes and mult/div timer states
package mips_pkg;

  localparam int REG_ADDR_W = 5;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } muldiv_state_e;

endpackage

// File: rtl/muldiv_timer.sv
// rtl/muldiv_timer.sv - mult/div occupancy timer, busy for CYCLES cycles after a start
module muldiv_timer
  import mips_pkg::*;
#(
  parameter int CYCLES = 32
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  output logic busy
);

  muldiv_state_e state_q, state_d;
  logic [7:0]    cnt_q, cnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // A start seen while already BUSY is dropped; the count is never reloaded.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = BUSY;
          cnt_d   = 8'(CYCLES - 1);
        end
      end
      BUSY: begin
        if (cnt_q == 8'd0) state_d = IDLE;
        else               cnt_d   = cnt_q - 8'd1;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy = (state_q == BUSY);

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - pipeline stall/flush/forward control; HAZARD_CTRL_MULDIV_EN adds mult/div interlock
module hazard_ctrl
  import mips_pkg::*;
#(
  parameter int REG_ADDR_W    = mips_pkg::REG_ADDR_W,
  parameter int MULDIV_CYCLES = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic                  id_uses_rs,
  input  logic                  id_uses_rt,
  input  logic                  id_uses_hilo,
  input  logic [REG_ADDR_W-1:0] ex_rs,
  input  logic [REG_ADDR_W-1:0] ex_rt,
  input  logic [REG_ADDR_W-1:0] ex_dest,
  input  logic                  ex_reg_write,
  input  logic                  ex_mem_read,
  input  logic [REG_ADDR_W-1:0] mem_dest,
  input  logic [REG_ADDR_W-1:0] wb_dest,
  input  logic                  mem_reg_write,
  input  logic                  wb_reg_write,
  input  logic                  ex_branch_taken,
  input  logic                  ex_muldiv_start,
  output logic                  pc_en,
  output logic                  if_id_en,
  output logic                  id_ex_en,
  output logic                  if_id_flush,
  output logic                  id_ex_flush,
  output logic [1:0]            fwd_a,
  output logic [1:0]            fwd_b,
  output logic                  muldiv_busy,
  output logic [15:0]           stall_count
);

  localparam logic [REG_ADDR_W-1:0] R0 = '0;

  logic load_use, hilo_stall, stall;
  logic mem_fwd_ok, wb_fwd_ok;
  logic [15:0] stall_count_q, stall_count_d;

`ifdef HAZARD_CTRL_MULDIV_EN
  muldiv_timer #(.CYCLES(MULDIV_CYCLES)) u_muldiv_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .start (ex_muldiv_start),
    .busy  (muldiv_busy)
  );
  assign hilo_stall = muldiv_busy & id_uses_hilo;
`else
  logic unused_muldiv;
  assign unused_muldiv = &{1'b0, ex_muldiv_start, id_uses_hilo};
  assign muldiv_busy   = 1'b0;
  assign hilo_stall    = 1'b0;
`endif

  // ex_reg_write is implied by ex_mem_read for loads, so only the load qualifier matters.
  logic unused_ex_wr;
  assign unused_ex_wr = &{1'b0, ex_reg_write};

  assign load_use = ex_mem_read && (ex_dest != R0) &&
                    ((id_uses_rs && (id_rs == ex_dest)) ||
                     (id_uses_rt && (id_rt == ex_dest)));
  assign stall    = load_use | hilo_stall;

  always_comb begin
    pc_en       = 1'b1;
    if_id_en    = 1'b1;
    id_ex_en    = 1'b1;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    if (!rst_n) begin
      pc_en       = 1'b0;
      if_id_en    = 1'b0;
      id_ex_en    = 1'b0;
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else if (ex_branch_taken) begin
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else if (stall) begin
      pc_en       = 1'b0;
      if_id_en    = 1'b0;
      id_ex_flush = 1'b1;
    end
  end

  assign mem_fwd_ok = mem_reg_write && (mem_dest != R0);
  assign wb_fwd_ok  = wb_reg_write  && (wb_dest  != R0);

  always_comb begin
    fwd_a = FWD_RF;
    fwd_b = FWD_RF;
    if (rst_n) begin
      if      (mem_fwd_ok && (mem_dest == ex_rs)) fwd_a = FWD_MEM;
      else if (wb_fwd_ok  && (wb_dest  == ex_rs)) fwd_a = FWD_WB;
      if      (mem_fwd_ok && (mem_dest == ex_rt)) fwd_b = FWD_MEM;
      else if (wb_fwd_ok  && (wb_dest  == ex_rt)) fwd_b = FWD_WB;
    end
  end

  always_comb begin
    stall_count_d = stall_count_q;
    if (!pc_en && (stall_count_q != 16'hFFFF)) stall_count_d = stall_count_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stall_count_q <= 16'd0;
    else        stall_count_q <= stall_count_d;
  end

  assign stall_count = stall_count_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - directed self-checking bench for hazard_ctrl
module tb_hazard_ctrl;

  logic       clk, rst_n;
  logic [4:0] id_rs, id_rt, ex_rs, ex_rt, ex_dest, mem_dest, wb_dest;
  logic       id_uses_rs, id_uses_rt, id_uses_hilo;
  logic       ex_reg_write, ex_mem_read, mem_reg_write, wb_reg_write;
  logic       ex_branch_taken, ex_muldiv_start;
  logic       pc_en, if_id_en, id_ex_en, if_id_flush, id_ex_flush, muldiv_busy;
  logic [1:0] fwd_a, fwd_b;
  logic [15:0] stall_count;

  int checks = 0;
  int failures = 0;

  hazard_ctrl #(.REG_ADDR_W(5), .MULDIV_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .id_uses_hilo(id_uses_hilo),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_dest(ex_dest),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .mem_dest(mem_dest), .wb_dest(wb_dest),
    .mem_reg_write(mem_reg_write), .wb_reg_write(wb_reg_write),
    .ex_branch_taken(ex_branch_taken), .ex_muldiv_start(ex_muldiv_start),
    .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_en(id_ex_en),
    .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
    .fwd_a(fwd_a), .fwd_b(fwd_b),
    .muldiv_busy(muldiv_busy), .stall_count(stall_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clear_inputs();
    id_rs = 0; id_rt = 0; ex_rs = 0; ex_rt = 0; ex_dest = 0; mem_dest = 0; wb_dest = 0;
    id_uses_rs = 0; id_uses_rt = 0; id_uses_hilo = 0;
    ex_reg_write = 0; ex_mem_read = 0; mem_reg_write = 0; wb_reg_write = 0;
    ex_branch_taken = 0; ex_muldiv_start = 0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst_n = 1'b0;
    mem_reg_write = 1; mem_dest = 7; ex_rs = 7; ex_rt = 7;
    #2;
    checks++; if ({pc_en, if_id_en, id_ex_en} !== 3'b000) begin failures++; $display("FAIL reset_en got=%b want=000", {pc_en, if_id_en, id_ex_en}); end
    checks++; if ({if_id_flush, id_ex_flush} !== 2'b11) begin failures++; $display("FAIL reset_flush got=%b want=11", {if_id_flush, id_ex_flush}); end
    checks++; if ({fwd_a, fwd_b} !== 4'b0000) begin failures++; $display("FAIL reset_fwd got=%b want=0000", {fwd_a, fwd_b}); end
    checks++; if (stall_count !== 16'd0 || muldiv_busy !== 1'b0) begin failures++; $display("FAIL reset_cnt got=%0d/%b want=0/0", stall_count, muldiv_busy); end
    @(negedge clk); @(negedge clk);
    clear_inputs();
    rst_n = 1'b1;
    #1;
    checks++; if ({pc_en, if_id_en, id_ex_en, if_id_flush, id_ex_flush} !== 5'b11100) begin failures++; $display("FAIL idle_ctrl got=%b want=11100", {pc_en, if_id_en, id_ex_en, if_id_flush, id_ex_flush}); end
    @(negedge clk);
    checks++; if (stall_count !== 16'd0) begin failures++; $display("FAIL idle_cnt got=%0d want=0", stall_count); end
  endtask

  task automatic test_load_use();
    clear_inputs();
    ex_mem_read = 1; ex_reg_write = 1; ex_dest = 5; id_rs = 5; id_uses_rs = 1;
    #1;
    checks++; if ({pc_en, if_id_en, id_ex_en, if_id_flush, id_ex_flush} !== 5'b00101) begin failures++; $display("FAIL load_use_ctrl got=%b want=00101", {pc_en, if_id_en, id_ex_en, if_id_flush, id_ex_flush}); end
    @(negedge clk);
    clear_inputs();
    #1;
    checks++; if (stall_count !== 16'd1) begin failures++; $display("FAIL load_use_cnt got=%0d want=1", stall_count); end
    checks++; if (pc_en !== 1'b1) begin failures++; $display("FAIL load_use_release got=%b want=1", pc_en); end
    // rt match not qualified by id_uses_rt, and a load into r0, must not stall
    ex_mem_read = 1; ex_dest = 6; id_rt = 6; id_uses_rt = 0; id_rs = 3; id_uses_rs = 1;
    #1;
    checks++; if (pc_en !== 1'b1) begin failures++; $display("FAIL unqualified_rt got=%b want=1", pc_en); end
    ex_dest = 0; id_rs = 0; id_rt = 0; id_uses_rt = 1;
    #1;
    checks++; if (pc_en !== 1'b1 || id_ex_flush !== 1'b0) begin failures++; $display("FAIL r0_stall got=%b%b want=10", pc_en, id_ex_flush); end
    ex_dest = 9; id_rt = 9;
    #1;
    checks++; if (pc_en !== 1'b0) begin failures++; $display("FAIL rt_stall got=%b want=0", pc_en); end
    @(negedge clk);
    clear_inputs();
    #1;
    checks++; if (stall_count !== 16'd2) begin failures++; $display("FAIL rt_stall_cnt got=%0d want=2", stall_count); end
  endtask

  task automatic test_branch();
    clear_inputs();
    ex_mem_read = 1; ex_dest = 5; id_rs = 5; id_uses_rs = 1; ex_branch_taken = 1;
    #1;
    checks++; if ({pc_en, if_id_en, id_ex_en, if_id_flush, id_ex_flush} !== 5'b11111) begin failures++; $display("FAIL branch_ctrl got=%b want=11111", {pc_en, if_id_en, id_ex_en, if_id_flush, id_ex_flush}); end
    @(negedge clk);
    clear_inputs();
    #1;
    checks++; if (stall_count !== 16'd2) begin failures++; $display("FAIL branch_cnt got=%0d want=2", stall_count); end
  endtask

  task automatic test_forward();
    clear_inputs();
    mem_reg_write = 1; wb_reg_write = 1; mem_dest = 7; wb_dest = 7; ex_rs = 7; ex_rt = 2;
    #1;
    checks++; if (fwd_a !== 2'b01 || fwd_b !== 2'b00) begin failures++; $display("FAIL fwd_mem_prio got=%b/%b want=01/00", fwd_a, fwd_b); end
    mem_reg_write = 0;
    #1;
    checks++; if (fwd_a !== 2'b10) begin failures++; $display("FAIL fwd_wb got=%b want=10", fwd_a); end
    mem_reg_write = 1; mem_dest = 4; wb_dest = 3; ex_rs = 4; ex_rt = 3;
    #1;
    checks++; if (fwd_a !== 2'b01 || fwd_b !== 2'b10) begin failures++; $display("FAIL fwd_split got=%b/%b want=01/10", fwd_a, fwd_b); end
    mem_dest = 0; wb_dest = 0; ex_rs = 0; ex_rt = 0;
    #1;
    checks++; if (fwd_a !== 2'b00 || fwd_b !== 2'b00) begin failures++; $display("FAIL fwd_r0 got=%b/%b want=00/00", fwd_a, fwd_b); end
    mem_dest = 8; wb_dest = 8; ex_rt = 8; mem_reg_write = 0; wb_reg_write = 0;
    #1;
    checks++; if (fwd_b !== 2'b00) begin failures++; $display("FAIL fwd_nowrite got=%b want=00", fwd_b); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    clear_inputs();
    ex_mem_read = 1; ex_dest = 12; id_rs = 12; id_uses_rs = 1;
    @(negedge clk);
    ex_dest = 13; id_rt = 13; id_uses_rt = 1;
    #1;
    checks++; if (pc_en !== 1'b0) begin failures++; $display("FAIL b2b_second got=%b want=0", pc_en); end
    @(negedge clk);
    clear_inputs();
    #1;
    checks++; if (stall_count !== 16'd4) begin failures++; $display("FAIL b2b_cnt got=%0d want=4", stall_count); end
  endtask

`ifdef HAZARD_CTRL_MULDIV_EN
  task automatic test_muldiv();
    int base;
    clear_inputs();
    base = stall_count;
    ex_muldiv_start = 1; id_uses_hilo = 1;
    #1;
    checks++; if (muldiv_busy !== 1'b0 || pc_en !== 1'b1) begin failures++; $display("FAIL md_start got=%b%b want=01", muldiv_busy, pc_en); end
    @(negedge clk);
    ex_muldiv_start = 0;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++; if (muldiv_busy !== 1'b1 || pc_en !== 1'b0) begin failures++; $display("FAIL md_busy_%0d got=%b%b want=10", i, muldiv_busy, pc_en); end
      @(negedge clk);
    end
    #1;
    checks++; if (muldiv_busy !== 1'b0 || pc_en !== 1'b1) begin failures++; $display("FAIL md_done got=%b%b want=01", muldiv_busy, pc_en); end
    checks++; if (stall_count !== 16'(base + 4)) begin failures++; $display("FAIL md_cnt got=%0d want=%0d", stall_count, base + 4); end
    id_uses_hilo = 0;
    ex_muldiv_start = 1;
    @(negedge clk);
    ex_muldiv_start = 0;
    #1;
    checks++; if (muldiv_busy !== 1'b1 || pc_en !== 1'b1) begin failures++; $display("FAIL md_indep got=%b%b want=11", muldiv_busy, pc_en); end
    id_uses_hilo = 1;
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (muldiv_busy !== 1'b0 || stall_count !== 16'd0) begin failures++; $display("FAIL md_reset got=%b/%0d want=0/0", muldiv_busy, stall_count); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++; if (pc_en !== 1'b1 || muldiv_busy !== 1'b0) begin failures++; $display("FAIL md_after_reset got=%b%b want=10", pc_en, muldiv_busy); end
    @(negedge clk);
    #1;
    checks++; if (stall_count !== 16'd0) begin failures++; $display("FAIL md_after_cnt got=%0d want=0", stall_count); end
    clear_inputs();
  endtask
`else
  task automatic test_muldiv();
    clear_inputs();
    ex_muldiv_start = 1; id_uses_hilo = 1;
    @(negedge clk);
    ex_muldiv_start = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (muldiv_busy !== 1'b0 || pc_en !== 1'b1) begin failures++; $display("FAIL md_off_%0d got=%b%b want=01", i, muldiv_busy, pc_en); end
      @(negedge clk);
    end
    clear_inputs();
  endtask
`endif

  initial begin
    test_reset();
    test_load_use();
    test_branch();
    test_forward();
    test_back_to_back();
    test_muldiv();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
